// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings for the semiMIPS hazard/stall controller: FSM states and
// the opcode/funct values the instruction classifier looks for.
package hazard_stall_ctrl_pkg;

   typedef enum logic {
      RUN    = 1'b0,
      MDWAIT = 1'b1
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: IF/ID and ID/EX hazard
// inputs from the datapath and the enables/flushes sent back to it.
interface hazard_stall_ctrl_if #(
   parameter int STALL_W = 16
);
   logic [31:0]        ifidins;
   logic               idexmemrd;
   logic [4:0]         idexrt;
   logic               exbrtaken;
   logic               pcwr;
   logic               ifidwr;
   logic               ifidflush;
   logic               idexflush;
   logic               mdstart;
   logic               mdbusy;
   logic [STALL_W-1:0] stallcnt;

   // Datapath side: presents pipeline state, consumes the controls.
   modport master (
      output ifidins, idexmemrd, idexrt, exbrtaken,
      input  pcwr, ifidwr, ifidflush, idexflush, mdstart, mdbusy, stallcnt
   );

   // Controller side.
   modport slave (
      input  ifidins, idexmemrd, idexrt, exbrtaken,
      output pcwr, ifidwr, ifidflush, idexflush, mdstart, mdbusy, stallcnt
   );
endinterface

// File: rtl/hazard_stall_ctrl_ins_class_decode.sv
// Combinational classifier for the instruction sitting in IF/ID: register
// fields plus the few instruction classes that matter for hazard detection.
module ins_class_decode
   import hazard_stall_ctrl_pkg::*;
(
   input  logic [31:0] ins_i,
   output logic [4:0]  rs_o,
   output logic [4:0]  rt_o,
   output logic        usesrt_o,
   output logic        md_o,
   output logic        mfhilo_o
);
   logic [5:0] op;
   logic [5:0] fn;
   logic       unused_fields;

   assign op = ins_i[31:26];
   assign fn = ins_i[5:0];
   assign rs_o = ins_i[25:21];
   assign rt_o = ins_i[20:16];
   // rd/shamt/immediate bits carry no hazard information here.
   assign unused_fields = ^ins_i[15:6];

   // Class flags: rt is a source only for R-type, beq/bne and sw.
   always_comb begin
      usesrt_o = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
      md_o     = (op == OP_RTYPE) &&
                 ((fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU));
      mfhilo_o = (op == OP_RTYPE) && ((fn == FN_MFHI) || (fn == FN_MFLO));
   end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard sequencing for the 5-stage semiMIPS pipeline: load-use bubble,
// mult/div busy window, taken-branch flush, and a saturating stall counter.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MD_LATENCY = 32,
   parameter int STALL_W    = 16
) (
   input logic                 clk,
   input logic                 rst,
   hazard_stall_ctrl_if.slave  bus
);
   localparam logic [7:0] MD_INIT = 8'(MD_LATENCY - 1);

   state_e             state_q, state_d;
   logic [7:0]         mdcnt_q, mdcnt_d;
   logic [STALL_W-1:0] stallcnt_q, stallcnt_d;

   logic [4:0] rs, rt;
   logic       usesrt, md, mfhilo;
   logic       loaduse, stall;
   logic       pcwr, ifidwr, ifidflush, idexflush, mdstart;

   ins_class_decode u_dec (
      .ins_i    (bus.ifidins),
      .rs_o     (rs),
      .rt_o     (rt),
      .usesrt_o (usesrt),
      .md_o     (md),
      .mfhilo_o (mfhilo)
   );

   // Hazard detection: a load into a register read by ID, or an md/mfhi/mflo
   // in ID while the unit is still busy.
   always_comb begin
      loaduse = bus.idexmemrd && (bus.idexrt != 5'd0) &&
                ((bus.idexrt == rs) || (usesrt && (bus.idexrt == rt)));
      stall   = loaduse || ((state_q == MDWAIT) && (md || mfhilo));
   end

   // Pipeline controls by priority: reset, taken branch, stall, normal flow.
   // The branch wins over a stall because the ID instruction is discarded.
   always_comb begin
      pcwr      = 1'b1;
      ifidwr    = 1'b1;
      ifidflush = 1'b0;
      idexflush = 1'b0;
      mdstart   = 1'b0;
      if (rst) begin
         pcwr      = 1'b0;
         ifidwr    = 1'b0;
         ifidflush = 1'b1;
         idexflush = 1'b1;
      end else if (bus.exbrtaken) begin
         ifidflush = 1'b1;
         idexflush = 1'b1;
      end else if (stall) begin
         pcwr      = 1'b0;
         ifidwr    = 1'b0;
         idexflush = 1'b1;
      end else begin
         mdstart   = md && (state_q == RUN);
      end
   end

   // Busy-window sequencing and stall accounting. A branch in EX never ends
   // the window: the issued mult/div is older than the branch.
   always_comb begin
      state_d    = state_q;
      mdcnt_d    = mdcnt_q;
      stallcnt_d = stallcnt_q;
      case (state_q)
         RUN: begin
            if (mdstart) begin
               state_d = MDWAIT;
               mdcnt_d = MD_INIT;
            end
         end
         MDWAIT: begin
            mdcnt_d = mdcnt_q - 8'd1;
            if (mdcnt_q == 8'd1) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
      if (!pcwr && (stallcnt_q != '1)) begin
         stallcnt_d = stallcnt_q + 1'b1;
      end
   end

   // State registers; reset abandons any in-flight mult/div window.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         mdcnt_q    <= 8'd0;
         stallcnt_q <= '0;
      end else begin
         state_q    <= state_d;
         mdcnt_q    <= mdcnt_d;
         stallcnt_q <= stallcnt_d;
      end
   end

   assign bus.pcwr      = pcwr;
   assign bus.ifidwr    = ifidwr;
   assign bus.ifidflush = ifidflush;
   assign bus.idexflush = idexflush;
   assign bus.mdstart   = mdstart;
   assign bus.mdbusy    = !rst && (state_q == MDWAIT);
   assign bus.stallcnt  = stallcnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl with MD_LATENCY=4 and a 4-bit stall counter.
// Control vector order: {pcwr, ifidwr, ifidflush, idexflush, mdstart, mdbusy}.
module tb_hazard_stall_ctrl;
   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   hazard_stall_ctrl_if #(.STALL_W(4)) bus ();

   hazard_stall_ctrl #(.MD_LATENCY(4), .STALL_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic [31:0] ins;
      logic        memrd;
      logic [4:0]  rt;
      logic        br;
      logic [5:0]  ctl;
      logic [3:0]  cnt;
   } step_t;

   typedef struct {
      logic [5:0] ctl;
      logic [3:0] cnt;
   } exp_t;

   exp_t sbq[$];

   localparam logic [5:0] C_RST   = 6'b001100;
   localparam logic [5:0] C_RUN   = 6'b110000;
   localparam logic [5:0] C_MDST  = 6'b110010;
   localparam logic [5:0] C_STALL = 6'b000100;
   localparam logic [5:0] C_BUSY  = 6'b110001;
   localparam logic [5:0] C_BSTL  = 6'b000101;
   localparam logic [5:0] C_BR    = 6'b111100;
   localparam logic [5:0] C_BRBSY = 6'b111101;

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   logic [31:0] ADD981, ADD900, SW8, ADDI82, ADDI98, MULT45, MFLO3;

   task automatic apply(input step_t s);
      rst           = s.r;
      bus.ifidins   = s.ins;
      bus.idexmemrd = s.memrd;
      bus.idexrt    = s.rt;
      bus.exbrtaken = s.br;
   endtask

   task automatic do_reset();
      apply('{1'b1, ADD900, 1'b0, 5'd0, 1'b0, C_RST, 4'd0});
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step_t tbl[$];
      exp_t  e;
      rst = 1'b1;
      @(posedge clk);
      #1;
      tbl.push_back('{1'b1, ADD981, 1'b0, 5'd0, 1'b0, C_RST, 4'd0});
      tbl.push_back('{1'b1, MULT45, 1'b1, 5'd8, 1'b0, C_RST, 4'd0});
      tbl.push_back('{1'b0, ADD900, 1'b0, 5'd0, 1'b0, C_RUN, 4'd0});
      foreach (tbl[i]) begin
         apply(tbl[i]);
         sbq.push_back('{tbl[i].ctl, tbl[i].cnt});
         @(negedge clk);
         e = sbq.pop_front();
         total++;
         if ({bus.pcwr, bus.ifidwr, bus.ifidflush, bus.idexflush, bus.mdstart, bus.mdbusy} !== e.ctl) begin
            bad++;
            $display("FAIL reset[%0d] ctl got=%b want=%b", i,
                     {bus.pcwr, bus.ifidwr, bus.ifidflush, bus.idexflush, bus.mdstart, bus.mdbusy}, e.ctl);
         end
         total++;
         if (bus.stallcnt !== e.cnt) begin
            bad++;
            $display("FAIL reset[%0d] stallcnt got=%0d want=%0d", i, bus.stallcnt, e.cnt);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_load_use();
      step_t tbl[$];
      exp_t  e;
      do_reset();
      tbl.push_back('{1'b0, ADD981, 1'b1, 5'd8, 1'b0, C_STALL, 4'd0});
      tbl.push_back('{1'b0, ADD981, 1'b0, 5'd8, 1'b0, C_RUN,   4'd1});
      tbl.push_back('{1'b0, SW8,    1'b1, 5'd8, 1'b0, C_STALL, 4'd1});
      tbl.push_back('{1'b0, SW8,    1'b0, 5'd8, 1'b0, C_RUN,   4'd2});
      tbl.push_back('{1'b0, ADDI82, 1'b1, 5'd8, 1'b0, C_RUN,   4'd2});
      tbl.push_back('{1'b0, ADD900, 1'b1, 5'd0, 1'b0, C_RUN,   4'd2});
      tbl.push_back('{1'b0, ADDI98, 1'b1, 5'd8, 1'b0, C_STALL, 4'd2});
      tbl.push_back('{1'b0, ADDI98, 1'b0, 5'd0, 1'b0, C_RUN,   4'd3});
      foreach (tbl[i]) begin
         apply(tbl[i]);
         sbq.push_back('{tbl[i].ctl, tbl[i].cnt});
         @(negedge clk);
         e = sbq.pop_front();
         total++;
         if ({bus.pcwr, bus.ifidwr, bus.ifidflush, bus.idexflush, bus.mdstart, bus.mdbusy} !== e.ctl) begin
            bad++;
            $display("FAIL loaduse[%0d] ctl got=%b want=%b", i,
                     {bus.pcwr, bus.ifidwr, bus.ifidflush, bus.idexflush, bus.mdstart, bus.mdbusy}, e.ctl);
         end
         total++;
         if (bus.stallcnt !== e.cnt) begin
            bad++;
            $display("FAIL loaduse[%0d] stallcnt got=%0d want=%0d", i, bus.stallcnt, e.cnt);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_mult_div();
      step_t tbl[$];
      exp_t  e;
      do_reset();
      // mult then a dependent mflo held for the 3-cycle busy window
      tbl.push_back('{1'b0, MULT45, 1'b0, 5'd0, 1'b0, C_MDST,  4'd0});
      tbl.push_back('{1'b0, MFLO3,  1'b0, 5'd0, 1'b0, C_BSTL,  4'd0});
      tbl.push_back('{1'b0, MFLO3,  1'b0, 5'd0, 1'b0, C_BSTL,  4'd1});
      tbl.push_back('{1'b0, MFLO3,  1'b0, 5'd0, 1'b0, C_BSTL,  4'd2});
      tbl.push_back('{1'b0, MFLO3,  1'b0, 5'd0, 1'b0, C_RUN,   4'd3});
      // mult then unrelated instructions, with a branch inside the window
      tbl.push_back('{1'b0, MULT45, 1'b0, 5'd0, 1'b0, C_MDST,  4'd3});
      tbl.push_back('{1'b0, ADD981, 1'b0, 5'd0, 1'b0, C_BUSY,  4'd3});
      tbl.push_back('{1'b0, ADD981, 1'b0, 5'd0, 1'b1, C_BRBSY, 4'd3});
      tbl.push_back('{1'b0, ADD981, 1'b0, 5'd0, 1'b0, C_BUSY,  4'd3});
      tbl.push_back('{1'b0, ADD981, 1'b0, 5'd0, 1'b0, C_RUN,   4'd3});
      // back-to-back mult waits out the window then issues
      tbl.push_back('{1'b0, MULT45, 1'b0, 5'd0, 1'b0, C_MDST,  4'd3});
      tbl.push_back('{1'b0, MULT45, 1'b0, 5'd0, 1'b0, C_BSTL,  4'd3});
      tbl.push_back('{1'b0, MULT45, 1'b0, 5'd0, 1'b0, C_BSTL,  4'd4});
      tbl.push_back('{1'b0, MULT45, 1'b0, 5'd0, 1'b0, C_BSTL,  4'd5});
      tbl.push_back('{1'b0, MULT45, 1'b0, 5'd0, 1'b0, C_MDST,  4'd6});
      foreach (tbl[i]) begin
         apply(tbl[i]);
         sbq.push_back('{tbl[i].ctl, tbl[i].cnt});
         @(negedge clk);
         e = sbq.pop_front();
         total++;
         if ({bus.pcwr, bus.ifidwr, bus.ifidflush, bus.idexflush, bus.mdstart, bus.mdbusy} !== e.ctl) begin
            bad++;
            $display("FAIL multdiv[%0d] ctl got=%b want=%b", i,
                     {bus.pcwr, bus.ifidwr, bus.ifidflush, bus.idexflush, bus.mdstart, bus.mdbusy}, e.ctl);
         end
         total++;
         if (bus.stallcnt !== e.cnt) begin
            bad++;
            $display("FAIL multdiv[%0d] stallcnt got=%0d want=%0d", i, bus.stallcnt, e.cnt);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_branch();
      step_t tbl[$];
      exp_t  e;
      do_reset();
      // mult in ID reading $4 while a load to $4 is in EX, branch taken
      tbl.push_back('{1'b0, MULT45, 1'b1, 5'd4, 1'b1, C_BR,  4'd0});
      tbl.push_back('{1'b0, ADD981, 1'b0, 5'd0, 1'b0, C_RUN, 4'd0});
      tbl.push_back('{1'b0, ADD981, 1'b1, 5'd8, 1'b1, C_BR,  4'd0});
      tbl.push_back('{1'b0, ADD981, 1'b0, 5'd0, 1'b0, C_RUN, 4'd0});
      foreach (tbl[i]) begin
         apply(tbl[i]);
         sbq.push_back('{tbl[i].ctl, tbl[i].cnt});
         @(negedge clk);
         e = sbq.pop_front();
         total++;
         if ({bus.pcwr, bus.ifidwr, bus.ifidflush, bus.idexflush, bus.mdstart, bus.mdbusy} !== e.ctl) begin
            bad++;
            $display("FAIL branch[%0d] ctl got=%b want=%b", i,
                     {bus.pcwr, bus.ifidwr, bus.ifidflush, bus.idexflush, bus.mdstart, bus.mdbusy}, e.ctl);
         end
         total++;
         if (bus.stallcnt !== e.cnt) begin
            bad++;
            $display("FAIL branch[%0d] stallcnt got=%0d want=%0d", i, bus.stallcnt, e.cnt);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset_mid_md();
      step_t tbl[$];
      exp_t  e;
      do_reset();
      tbl.push_back('{1'b0, MULT45, 1'b0, 5'd0, 1'b0, C_MDST, 4'd0});
      tbl.push_back('{1'b0, MFLO3,  1'b0, 5'd0, 1'b0, C_BSTL, 4'd0});
      tbl.push_back('{1'b1, MFLO3,  1'b0, 5'd0, 1'b0, C_RST,  4'd1});
      tbl.push_back('{1'b1, MULT45, 1'b0, 5'd0, 1'b0, C_RST,  4'd0});
      tbl.push_back('{1'b0, MULT45, 1'b0, 5'd0, 1'b0, C_MDST, 4'd0});
      tbl.push_back('{1'b0, ADD981, 1'b0, 5'd0, 1'b0, C_BUSY, 4'd0});
      foreach (tbl[i]) begin
         apply(tbl[i]);
         sbq.push_back('{tbl[i].ctl, tbl[i].cnt});
         @(negedge clk);
         e = sbq.pop_front();
         total++;
         if ({bus.pcwr, bus.ifidwr, bus.ifidflush, bus.idexflush, bus.mdstart, bus.mdbusy} !== e.ctl) begin
            bad++;
            $display("FAIL rstmid[%0d] ctl got=%b want=%b", i,
                     {bus.pcwr, bus.ifidwr, bus.ifidflush, bus.idexflush, bus.mdstart, bus.mdbusy}, e.ctl);
         end
         total++;
         if (bus.stallcnt !== e.cnt) begin
            bad++;
            $display("FAIL rstmid[%0d] stallcnt got=%0d want=%0d", i, bus.stallcnt, e.cnt);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_saturate();
      step_t tbl[$];
      exp_t  e;
      int    n;
      do_reset();
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tbl.push_back('{1'b0, ADD981, 1'b1, 5'd8, 1'b0, C_STALL, 4'(n)});
         if (n < 15) n++;
      end
      tbl.push_back('{1'b0, ADD981, 1'b0, 5'd0, 1'b0, C_RUN, 4'd15});
      tbl.push_back('{1'b0, ADD981, 1'b0, 5'd0, 1'b0, C_RUN, 4'd15});
      foreach (tbl[i]) begin
         apply(tbl[i]);
         sbq.push_back('{tbl[i].ctl, tbl[i].cnt});
         @(negedge clk);
         e = sbq.pop_front();
         total++;
         if ({bus.pcwr, bus.ifidwr, bus.ifidflush, bus.idexflush, bus.mdstart, bus.mdbusy} !== e.ctl) begin
            bad++;
            $display("FAIL saturate[%0d] ctl got=%b want=%b", i,
                     {bus.pcwr, bus.ifidwr, bus.ifidflush, bus.idexflush, bus.mdstart, bus.mdbusy}, e.ctl);
         end
         total++;
         if (bus.stallcnt !== e.cnt) begin
            bad++;
            $display("FAIL saturate[%0d] stallcnt got=%0d want=%0d", i, bus.stallcnt, e.cnt);
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      ADD981 = rtype(5'd8, 5'd1, 5'd9, 6'h20);
      ADD900 = rtype(5'd0, 5'd0, 5'd9, 6'h20);
      SW8    = itype(6'h2B, 5'd2, 5'd8, 16'h0000);
      ADDI82 = itype(6'h08, 5'd2, 5'd8, 16'h0005);
      ADDI98 = itype(6'h08, 5'd8, 5'd9, 16'h0001);
      MULT45 = rtype(5'd4, 5'd5, 5'd0, 6'h18);
      MFLO3  = rtype(5'd0, 5'd0, 5'd3, 6'h12);
      clk           = 1'b0;
      rst           = 1'b1;
      bus.ifidins   = 32'd0;
      bus.idexmemrd = 1'b0;
      bus.idexrt    = 5'd0;
      bus.exbrtaken = 1'b0;
      test_reset();
      test_load_use();
      test_mult_div();
      test_branch();
      test_reset_mid_md();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage semiMIPS core; sits beside the forwarding unit.
- Covers the hazards that forwarding cannot resolve:
  - load-use stall: one-cycle bubble.
  - multi-cycle mult/div occupancy: counter-sequenced busy window; mfhi/mflo/mult/div in ID wait for it.
  - taken-branch flush from EX.
- Drives PC write enable, IF/ID write enable and flushes, ID/EX flush, the mult/div start pulse, and a stall-cycle performance counter.

Parameters:
- MD_LATENCY, 32, cycles the mult/div unit needs after mdstart; legal range 2..255.
- STALL_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ifidins  input  32  instruction currently in IF/ID.
- idexmemrd  input  1  ID/EX instruction is a load.
- idexrt  input  5  ID/EX rt, the load destination.
- exbrtaken  input  1  branch or jump resolved taken in EX this cycle.
- pcwr  output  1  PC write enable.
- ifidwr  output  1  IF/ID register write enable.
- ifidflush  output  1  IF/ID becomes a nop next edge.
- idexflush  output  1  ID/EX becomes a bubble next edge; all control bits cleared.
- mdstart  output  1  one-cycle pulse: the mult/div in ID advances to EX this edge.
- mdbusy  output  1  mult/div unit occupied.
- stallcnt  output  STALL_W  count of cycles with pcwr==0 since reset.

Behaviour:
- Decode of ifidins, combinational:
  - rs = [25:21], rt = [20:16].
  - usesrt = opcode 0x00, 0x04, 0x05 or 0x2B.
  - md = opcode 0x00 and funct in 0x18..0x1B.
  - mfhilo = opcode 0x00 and funct 0x10 or 0x12.
- loaduse = idexmemrd && idexrt!=0 && (idexrt==rs || (usesrt && idexrt==rt)).
- States: RUN, MDWAIT. Counter mdcnt is 8 bits.
- While rst=1:
  - outputs: pcwr=0, ifidwr=0, ifidflush=1, idexflush=1, mdstart=0, mdbusy=0.
  - next state RUN; mdcnt=0; stallcnt=0.
  - Reset mid-MDWAIT abandons the operation, with no mdstart afterwards.
- Output priority when rst=0; all outputs are Mealy (combinational from state and inputs):
  1. exbrtaken: pcwr=1, ifidwr=1, ifidflush=1, idexflush=1, mdstart=0. Overrides every stall. The ID instruction is discarded, so no mdstart.
  2. stall = loaduse || (state==MDWAIT && (md || mfhilo)): pcwr=0, ifidwr=0, ifidflush=0, idexflush=1, mdstart=0.
  3. otherwise: pcwr=1, ifidwr=1, both flushes 0; mdstart = md && state==RUN.
- mdbusy = (state==MDWAIT).
- Transitions:
  - RUN --mdstart--> MDWAIT, with mdcnt=MD_LATENCY-1.
  - MDWAIT: mdcnt decrements each cycle; when mdcnt==1 the next state is RUN.
  - Result: mdbusy is high for exactly MD_LATENCY-1 cycles, starting the cycle after mdstart. A stalled md or mfhilo proceeds in the first RUN cycle.
- exbrtaken during MDWAIT does not cancel the busy window. The issued mult/div is always older than the branch in EX.
- Non-md instructions flow through MDWAIT unstalled unless loaduse.
- Load-use produces exactly one bubble: next cycle the load is in MEM, the forwarding path resolves it, and loaduse deasserts because ID/EX holds the bubble.
- stallcnt increments on every non-reset cycle with pcwr==0 and saturates at all-ones (no wrap).

Decomposition:
- Shared package:
  - state encoding (RUN=1'b0, MDWAIT=1'b1).
  - opcode constants: OP_RTYPE, OP_BEQ, OP_BNE, OP_SW.
  - funct constants: FN_MULT..FN_DIVU, FN_MFHI, FN_MFLO.
- One sub-module, ins_class_decode: ifidins -> rs, rt, usesrt, md, mfhilo. It is combinational and reusable by the forwarding logic.

Test Plan:
- lw $8 in ID/EX (idexmemrd=1, idexrt=8), add $9,$8,$1 in ID:
  - cycle 1: pcwr=0, ifidwr=0, idexflush=1.
  - next cycle (idexmemrd=0): pcwr=1, stallcnt=1.
- Load-use to rt with sw in ID (idexrt==rt) -> stall. Same case with addi (no usesrt) -> no stall. idexrt=0 -> never stall.
- mult in ID, MD_LATENCY=4:
  - mdstart pulse for one cycle; mdbusy=1 for the next 3 cycles.
  - mflo held in ID: pcwr=0 for those 3 cycles, proceeds on cycle 4.
  - unrelated add behind the mult is not stalled.
- exbrtaken=1 with loaduse=1 and mult in ID:
  - pcwr=1, ifidflush=1, idexflush=1, mdstart=0.
  - state stays RUN.
- rst asserted on the second cycle of MDWAIT:
  - next cycle: mdbusy=0, stallcnt=0, flushes=1.
  - after release: a new mult gets mdstart immediately.
- STALL_W=4 with 20 forced stall cycles -> stallcnt saturates at 15.
